// File: rtl/two_bit_comp_pkg.sv
// Shared definitions for the two-bit equality comparator.
// Holds only the operand width used by the top-level ports.
package two_bit_comp_pkg;
    localparam int unsigned OPND_W = 2;
endpackage

// File: rtl/two_bit_comp_eq1_cell.sv
// One-bit equality cell: output is high when both inputs carry the same value.
// Written as the explicit sum-of-products form of XNOR.
module eq1_cell (
    input  logic i0,
    input  logic i1,
    output logic eq
);
    assign eq = (~i0 & ~i1) | (i0 & i1);
endmodule

// File: rtl/two_bit_comp.sv
// Two-bit equality comparator with a combinational flag (aeqb) and a
// registered copy (eq) cleared asynchronously by rst_n.
module two_bit_comp
    import two_bit_comp_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [OPND_W-1:0] a,
    input  logic [OPND_W-1:0] b,
    output logic              aeqb,
    output logic              eq
);
    logic [OPND_W-1:0] w_bit_eq;
    logic              r_eq;

    eq1_cell u_eq_bit0 (
        .i0 (a[0]),
        .i1 (b[0]),
        .eq (w_bit_eq[0])
    );

    eq1_cell u_eq_bit1 (
        .i0 (a[1]),
        .i1 (b[1]),
        .eq (w_bit_eq[1])
    );

    // aeqb does not depend on clk or rst_n, so it stays valid during reset
    assign aeqb = w_bit_eq[1] & w_bit_eq[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_eq <= 1'b0;
        end else begin
            r_eq <= aeqb;
        end
    end

    assign eq = r_eq;
endmodule

// File: tb/tb_two_bit_comp.sv
// Self-checking bench for two_bit_comp: scoreboard of expected registered
// results plus direct checks of the combinational flag.
module tb_two_bit_comp;
    logic       clk;
    logic       rst_n;
    logic [1:0] a;
    logic [1:0] b;
    logic       aeqb;
    logic       eq;

    int unsigned n_checks;
    int unsigned n_errors;
    bit          q_eq[$];

    two_bit_comp dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .aeqb  (aeqb),
        .eq    (eq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    // Drive operands, record the expected registered value, and advance one edge.
    task automatic push_and_clock(input logic [1:0] av, input logic [1:0] bv);
        a = av;
        b = bv;
        q_eq.push_back(av == bv);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bit exp;
        rst_n = 1'b0;
        a = 2'b00;
        b = 2'b00;
        #2;
        n_checks++;
        if (aeqb !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_aeqb: got %b required 1", aeqb);
        end
        n_checks++;
        if (eq !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_eq: got %b required 0", eq);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (eq !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_eq_held_over_edge: got %b required 0", eq);
        end
        @(negedge clk);
        rst_n = 1'b1;
        push_and_clock(2'b00, 2'b00);
        exp = q_eq.pop_front();
        n_checks++;
        if (eq !== exp) begin
            n_errors++;
            $display("FAIL reset_first_capture: got %b required %b", eq, exp);
        end
    endtask

    task automatic test_vectors();
        logic [1:0] va[7] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b11, 2'b11};
        logic [1:0] vb[7] = '{2'b00, 2'b00, 2'b11, 2'b10, 2'b00, 2'b11, 2'b01};
        bit         ve[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 7; i++) begin
            a = va[i];
            b = vb[i];
            #1;
            n_checks++;
            if (aeqb !== ve[i]) begin
                n_errors++;
                $display("FAIL vector_%0d a=%b b=%b: got aeqb=%b required %b",
                         i, va[i], vb[i], aeqb, ve[i]);
            end
        end
    endtask

    task automatic test_exhaustive();
        bit exp;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                push_and_clock(i[1:0], j[1:0]);
                n_checks++;
                if (aeqb !== (i == j)) begin
                    n_errors++;
                    $display("FAIL exhaustive_aeqb a=%0d b=%0d: got %b required %b",
                             i, j, aeqb, (i == j));
                end
                exp = q_eq.pop_front();
                n_checks++;
                if (eq !== exp) begin
                    n_errors++;
                    $display("FAIL exhaustive_eq a=%0d b=%0d: got %b required %b",
                             i, j, eq, exp);
                end
            end
        end
    endtask

    task automatic test_latency();
        bit exp;
        push_and_clock(2'b10, 2'b10);
        exp = q_eq.pop_front();
        n_checks++;
        if (eq !== exp) begin
            n_errors++;
            $display("FAIL latency_edge_n: got %b required %b", eq, exp);
        end
        b = 2'b00;
        #1;
        n_checks++;
        if (aeqb !== 1'b0) begin
            n_errors++;
            $display("FAIL latency_aeqb_immediate: got %b required 0", aeqb);
        end
        @(negedge clk);
        n_checks++;
        if (eq !== 1'b1) begin
            n_errors++;
            $display("FAIL latency_eq_held: got %b required 1", eq);
        end
        push_and_clock(2'b10, 2'b00);
        exp = q_eq.pop_front();
        n_checks++;
        if (eq !== exp) begin
            n_errors++;
            $display("FAIL latency_edge_n1: got %b required %b", eq, exp);
        end
    endtask

    task automatic test_midrun_reset();
        bit exp;
        push_and_clock(2'b11, 2'b11);
        exp = q_eq.pop_front();
        n_checks++;
        if (eq !== exp) begin
            n_errors++;
            $display("FAIL midrun_pre: got %b required %b", eq, exp);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (eq !== 1'b0) begin
            n_errors++;
            $display("FAIL midrun_async_clear: got %b required 0", eq);
        end
        n_checks++;
        if (aeqb !== 1'b1) begin
            n_errors++;
            $display("FAIL midrun_aeqb: got %b required 1", aeqb);
        end
        @(negedge clk);
        rst_n = 1'b1;
        push_and_clock(2'b01, 2'b01);
        exp = q_eq.pop_front();
        n_checks++;
        if (eq !== exp) begin
            n_errors++;
            $display("FAIL midrun_recover: got %b required %b", eq, exp);
        end
    endtask

    task automatic test_back_to_back();
        bit exp;
        for (int k = 0; k < 24; k++) begin
            push_and_clock(2'($urandom_range(3)), 2'($urandom_range(3)));
            exp = q_eq.pop_front();
            n_checks++;
            if (eq !== exp) begin
                n_errors++;
                $display("FAIL back_to_back_%0d a=%b b=%b: got %b required %b",
                         k, a, b, eq, exp);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        a = 2'b00;
        b = 2'b00;
        test_reset();
        test_vectors();
        test_exhaustive();
        test_latency();
        test_midrun_reset();
        test_back_to_back();
        n_checks++;
        if (q_eq.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d entries left required 0", q_eq.size());
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
